pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register; replaces hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a data payload and a control bundle between stages under a valid/ready handshake.
//  Supports flush and bubble insertion, and keeps a saturating bubble counter for performance debug.
//  An optional 2-entry skid buffer registers in_ready to break long stall paths.
// PARAMETERS
//  DATA_W      128  payload width (PC+4, instr, operands, immediate, ...)
//  CTRL_W      16   control bundle width; zeroed whenever the stage holds a bubble
//  CLR_DATA    1    1: flush and reset also zero the data regs; 0: data regs keep their value
//  CNT_W       16   width of the bubble counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  flush       in   1       kill all held entries (branch/jump redirect)
//  in_valid    in   1       upstream entry valid
//  in_ready    out  1       stage can accept this cycle
//  in_data     in   DATA_W  upstream payload
//  in_ctrl     in   CTRL_W  upstream control bundle
//  out_valid   out  1       downstream entry valid
//  out_ready   in   1       downstream accepts (0 = stall)
//  out_data    out  DATA_W  held payload
//  out_ctrl    out  CTRL_W  held control; all zero when out_valid=0
//  bubble_cnt  out  CNT_W   count of cycles with out_valid=0 since reset; saturates
// BEHAVIOUR
//  - One clock (clk); reset rst_n is asynchronous, active-low. Reset values: out_valid=0, out_ctrl=0,
//    bubble_cnt=0, skid empty, out_data=0 (or unchanged if CLR_DATA=0). in_ready=1 after reset.
//  - Transfer in: in_valid&&in_ready at the edge. Transfer out: out_valid&&out_ready at the edge.
//  - Latency: one cycle from accepted input to out_valid. Data and ctrl are registered, never combinational.
//  - Bubble: out_ctrl = out_valid ? ctrl_q : 0. A stalled or empty stage never presents live control.
//  - Hold: while out_valid&&!out_ready, out_data and out_ctrl stay stable. Valid never drops without a
//    transfer or a flush.
//  - Flush priority: flush > out transfer > in transfer.
//    - On a flush cycle: in_ready=0; any input is dropped; all entries are invalidated at the edge;
//      ctrl is zeroed; data is zeroed iff CLR_DATA=1.
//    - Next cycle: out_valid=0 and in_ready=1.
//  - Simultaneous in and out transfer on a full main reg: new entry replaces the old one; no bubble.
//  - bubble_cnt increments each cycle out_valid=0 (flush cycles included) and holds at 2^CNT_W-1.
//    It is not cleared by flush.
//  - Reset asserted mid-operation: all entries are dropped at once, with no partial handshake.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined:
//    - Adds a skid entry behind the main reg.
//    - in_ready = !skid_valid (registered, with no combinational path from out_ready).
//    - Input taken while main is valid and out_ready=0 goes into skid.
//    - When main drains, skid moves to main on the same edge as the out transfer; skid then empties.
//    - Full = main+skid valid. In that state in_ready=0 and the stage holds 2 entries.
//    - Flush clears both entries.
//  PIPE_STAGE_SKID_EN undefined:
//    - Single entry only.
//    - in_ready = !flush && (!out_valid || out_ready), combinational from out_ready.
//    - Full throughput when out_ready=1.
// TESTING
//  1 Reset: rst_n=0 with in_valid=1, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, bubble_cnt=0;
//    release rst_n -> in_ready=1.
//  2 Stream: out_ready=1, inputs D=1..8 on back-to-back cycles -> outputs 1..8 one cycle later,
//    in order, no bubbles; bubble_cnt stays frozen.
//  3 Stall: out_ready=0 for 5 cycles with main holding D=3, ctrl=16'h00A5 -> out_data=3 and
//    out_ctrl=16'h00A5 stable throughout.
//    - No skid: in_ready=0 for the whole stall.
//    - Skid: D=4 accepted, then in_ready=0. On release, 3 then 4 are output.
//  4 Flush while full (skid, 2 entries) plus in_valid=1 D=9 -> next cycle: out_valid=0, out_ctrl=0,
//    out_data=0 (CLR_DATA=1), D=9 dropped, in_ready=1.
//  5 Bubble counter: CNT_W=4, 20 idle cycles -> bubble_cnt=15, held.
//  6 Random valid/ready/flush for 10k cycles vs scoreboard -> no loss/duplication except flushed
//    entries; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, bubble control and a saturating bubble counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry behind the main register, so in_ready is taken from a register.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned CTRL_W   = 16,
    parameter bit          CLR_DATA = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              main_v_q,    main_v_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              in_xfer;

    assign in_xfer = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_v_q,    skid_v_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Only flush and the skid flag reach in_ready; out_ready has no path to it.
    assign in_ready = !flush && !skid_v_q;

    always_comb begin
        main_v_d    = main_v_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_v_d    = 1'b0;
            main_ctrl_d = '0;
            skid_v_d    = 1'b0;
            skid_ctrl_d = '0;
            if (CLR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (!main_v_q || out_ready) begin
            if (skid_v_q) begin
                main_v_d    = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
                skid_ctrl_d = '0;
            end else if (in_xfer) begin
                main_v_d    = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else begin
                main_v_d    = 1'b0;
                main_ctrl_d = '0;
            end
        end else if (in_xfer) begin
            skid_v_d    = 1'b1;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_v_q    <= 1'b0;
            skid_ctrl_q <= '0;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end
`else
    assign in_ready = !flush && (!main_v_q || out_ready);

    always_comb begin
        main_v_d    = main_v_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        if (flush) begin
            main_v_d    = 1'b0;
            main_ctrl_d = '0;
            if (CLR_DATA) begin
                main_data_d = '0;
            end
        end else if (in_xfer) begin
            main_v_d    = 1'b1;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
        end else if (out_ready) begin
            main_v_d    = 1'b0;
            main_ctrl_d = '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q    <= 1'b0;
            main_ctrl_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    // With CLR_DATA=0 the payload registers carry no reset at all.
    generate
        if (CLR_DATA) begin : g_data_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_data_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
                    skid_data_q <= '0;
`endif
                end else begin
                    main_data_q <= main_data_d;
`ifdef PIPE_STAGE_SKID_EN
                    skid_data_q <= skid_data_d;
`endif
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                main_data_q <= main_data_d;
`ifdef PIPE_STAGE_SKID_EN
                skid_data_q <= skid_data_d;
`endif
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if ((!main_v_q || flush) && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_v_q ? main_ctrl_q : '0;

endmodule
